// File: rtl/pio_irq_gen_pkg.sv
//------------------------------------------------------------------------------
// Module      : pio_irq_pkg
// Description : Shared trigger-mode encoding, register map and limits for the
//               pio_irq_gen parallel input port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pio_irq_pkg;

    typedef enum logic [1:0] {
        MODE_RISE  = 2'b00,
        MODE_FALL  = 2'b01,
        MODE_BOTH  = 2'b10,
        MODE_LEVEL = 2'b11
    } mode_e;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
    localparam logic [2:0] ADDR_DEBOUNCE = 3'd4;

    localparam int c_MAX_WIDTH = 16;

endpackage

`default_nettype wire

// File: rtl/pio_irq_gen_if.sv
//------------------------------------------------------------------------------
// Module      : pio_irq_gen_if
// Description : Avalon-MM slave bus plus interrupt line of the PIO.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pio_irq_gen_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

`default_nettype wire

// File: rtl/pio_irq_gen_chan.sv
//------------------------------------------------------------------------------
// Module      : pio_irq_chan
// Description : One input channel: synchroniser, optional debounce filter
//               (PIO_IRQ_DEBOUNCE_EN), edge/level select and capture flop.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pio_irq_chan
    import pio_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef PIO_IRQ_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_W  = 16
`endif
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  i_in,
    input  wire mode_e                 i_mode,
    input  wire logic                  i_clr,
`ifdef PIO_IRQ_DEBOUNCE_EN
    input  wire logic [DEBOUNCE_W-1:0] i_period,
`endif
    output logic                       o_filt,
    output logic                       o_cap
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_f;
    logic                   r_prev;
    logic                   r_cap;
    logic                   w_event;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_IRQ_DEBOUNCE_EN
    localparam logic [DEBOUNCE_W-1:0] c_ONE = DEBOUNCE_W'(1);

    logic                  r_filt;
    logic [DEBOUNCE_W-1:0] r_cnt;

    // With the filter bypassed r_filt still tracks the input so that enabling
    // it later starts from the current level rather than a stale one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (i_period == '0) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
        end else if (w_sync == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt >= i_period - c_ONE) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
        end else if (r_cnt != '1) begin
            r_cnt  <= r_cnt + c_ONE;
        end
    end

    assign w_f = (i_period == '0) ? w_sync : r_filt;
`else
    assign w_f = w_sync;
`endif

    always_comb begin
        w_event = 1'b0;
        case (i_mode)
            MODE_RISE:  w_event = w_f & ~r_prev;
            MODE_FALL:  w_event = ~w_f & r_prev;
            MODE_BOTH:  w_event = w_f ^ r_prev;
            MODE_LEVEL: w_event = w_f;
            default:    w_event = 1'b0;
        endcase
    end

    // A new event always overrides a simultaneous software clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 1'b0;
            r_cap  <= 1'b0;
        end else begin
            r_prev <= w_f;
            r_cap  <= (r_cap & ~i_clr) | w_event;
        end
    end

    assign o_filt = w_f;
    assign o_cap  = r_cap;

endmodule

`default_nettype wire

// File: rtl/pio_irq_gen.sv
//------------------------------------------------------------------------------
// Module      : pio_irq_gen
// Description : Parametrised Avalon-MM input port with per-channel edge/level
//               interrupts; debounce filter enabled by PIO_IRQ_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pio_irq_gen
    import pio_irq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    pio_irq_gen_if.slave          bus,
    input  wire logic [WIDTH-1:0] in_port
);

    if (WIDTH < 1 || WIDTH > c_MAX_WIDTH || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_W < 1 || DEBOUNCE_W > 32) begin : g_bad_params
        $error("pio_irq_gen: parameter out of range");
    end

    logic                 w_wr;
    logic [2*WIDTH-1:0]   r_mode;
    logic [WIDTH-1:0]     r_mask;
    logic [WIDTH-1:0]     w_filt;
    logic [WIDTH-1:0]     w_cap;
    logic [31:0]          w_rdata;
    logic [31:0]          r_rdata;
    logic                 w_unused_wdata;

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_unused_wdata = ^bus.writedata;

`ifdef PIO_IRQ_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] r_debounce;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_debounce <= '0;
        else if (w_wr && bus.address == ADDR_DEBOUNCE)
            r_debounce <= bus.writedata[DEBOUNCE_W-1:0];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= '0;
            r_mask <= '0;
        end else if (w_wr) begin
            if (bus.address == ADDR_MODE) r_mode <= bus.writedata[2*WIDTH-1:0];
            if (bus.address == ADDR_MASK) r_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_irq_chan #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef PIO_IRQ_DEBOUNCE_EN
            ,
            .DEBOUNCE_W  (DEBOUNCE_W)
`endif
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_in     (in_port[i]),
            .i_mode   (mode_e'(r_mode[2*i +: 2])),
            .i_clr    (w_wr && bus.address == ADDR_CAPTURE && bus.writedata[i]),
`ifdef PIO_IRQ_DEBOUNCE_EN
            .i_period (r_debounce),
`endif
            .o_filt   (w_filt[i]),
            .o_cap    (w_cap[i])
        );
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA:     w_rdata[WIDTH-1:0]   = w_filt;
            ADDR_MODE:     w_rdata[2*WIDTH-1:0] = r_mode;
            ADDR_MASK:     w_rdata[WIDTH-1:0]   = r_mask;
            ADDR_CAPTURE:  w_rdata[WIDTH-1:0]   = w_cap;
`ifdef PIO_IRQ_DEBOUNCE_EN
            ADDR_DEBOUNCE: w_rdata[DEBOUNCE_W-1:0] = r_debounce;
`endif
            default:       w_rdata = '0;
        endcase
    end

    // Read data is sampled every cycle, independent of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rdata <= '0;
        else          r_rdata <= w_rdata;
    end

    assign bus.readdata = r_rdata;
    assign bus.irq      = |(w_cap & r_mask);

endmodule

`default_nettype wire

// File: tb/tb_pio_irq_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_pio_irq_gen
// Description : Directed self-checking bench for pio_irq_gen (WIDTH=8, 2 sync).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pio_irq_gen;
    import pio_irq_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_port;
    int         checks = 0;
    int         errors = 0;

    pio_irq_gen_if bus();

    pio_irq_gen #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .DEBOUNCE_W  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        tick();
        check(tag, bus.readdata, exp);
    endtask

    initial begin
        reset_n        = 1'b0;
        in_port        = 8'h01;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        repeat (3) tick();
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'h0, bus.irq}, 32'h0);

        // Input high through reset: rising event, irq exactly 3 edges after release
        reset_n        = 1'b1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = ADDR_MASK;
        bus.writedata  = 32'h1;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = ADDR_CAPTURE;
        tick();
        check("irq_edge2", {31'h0, bus.irq}, 32'h0);
        tick();
        check("irq_edge3", {31'h0, bus.irq}, 32'h1);
        tick();
        check("cap_after_reset", bus.readdata, 32'h1);
        rd_check("data_ch0", ADDR_DATA, 32'h1);
        wr(ADDR_CAPTURE, 32'h1);
        check("irq_after_clr0", {31'h0, bus.irq}, 32'h0);
        rd_check("cap_clr0", ADDR_CAPTURE, 32'h0);

        // Channel 3 falling edge
        wr(ADDR_MODE, 32'h40);
        wr(ADDR_MASK, 32'h08);
        in_port[3] = 1'b1;
        repeat (4) tick();
        rd_check("fall_no_rise", ADDR_CAPTURE, 32'h0);
        check("fall_no_rise_irq", {31'h0, bus.irq}, 32'h0);
        in_port[3] = 1'b0;
        repeat (2) tick();
        check("fall_irq_early", {31'h0, bus.irq}, 32'h0);
        tick();
        check("fall_irq", {31'h0, bus.irq}, 32'h1);
        rd_check("fall_cap", ADDR_CAPTURE, 32'h08);
        wr(ADDR_CAPTURE, 32'h08);
        check("fall_clr_irq", {31'h0, bus.irq}, 32'h0);
        rd_check("fall_clr_cap", ADDR_CAPTURE, 32'h0);

        // Channel 1 both edges; clear collides with the second event
        wr(ADDR_MODE, 32'h48);
        wr(ADDR_MASK, 32'h0A);
        in_port[1] = 1'b1;
        repeat (4) tick();
        rd_check("both_rise", ADDR_CAPTURE, 32'h02);
        in_port[1] = 1'b0;
        tick();
        tick();
        wr(ADDR_CAPTURE, 32'h02);
        rd_check("both_clr_race", ADDR_CAPTURE, 32'h02);
        wr(ADDR_CAPTURE, 32'h02);
        rd_check("both_clr", ADDR_CAPTURE, 32'h0);

        // Channel 2 level mode
        wr(ADDR_MODE, 32'h78);
        in_port[2] = 1'b1;
        repeat (4) tick();
        rd_check("level_set", ADDR_CAPTURE, 32'h04);
        wr(ADDR_CAPTURE, 32'h04);
        rd_check("level_reassert", ADDR_CAPTURE, 32'h04);
        in_port[2] = 1'b0;
        repeat (3) tick();
        wr(ADDR_CAPTURE, 32'h04);
        rd_check("level_clr", ADDR_CAPTURE, 32'h0);

        rd_check("mode_rb", ADDR_MODE, 32'h78);
        rd_check("mask_rb", ADDR_MASK, 32'h0A);

        // Unmapped addresses and DATA with all inputs high
        wr(3'd5, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd_check("addr5", 3'd5, 32'h0);
        rd_check("addr6", 3'd6, 32'h0);
        rd_check("addr7", 3'd7, 32'h0);
        in_port = 8'hFF;
        repeat (3) tick();
        rd_check("data_all", ADDR_DATA, 32'h0000_00FF);
        in_port = 8'h01;
        repeat (4) tick();
        wr(ADDR_CAPTURE, 32'hFF);
        rd_check("cap_all_clr", ADDR_CAPTURE, 32'h0);

`ifdef PIO_IRQ_DEBOUNCE_EN
        wr(ADDR_DEBOUNCE, 32'h4);
        rd_check("db_rb", ADDR_DEBOUNCE, 32'h4);
        wr(ADDR_MASK, 32'h10);
        in_port[4] = 1'b1;
        repeat (3) tick();
        in_port[4] = 1'b0;
        repeat (10) tick();
        check("db_glitch", {31'h0, bus.irq}, 32'h0);
        in_port[4] = 1'b1;
        repeat (5) tick();
        in_port[4] = 1'b0;
        tick();
        check("db_early", {31'h0, bus.irq}, 32'h0);
        tick();
        check("db_pulse", {31'h0, bus.irq}, 32'h1);
`else
        wr(ADDR_DEBOUNCE, 32'h4);
        rd_check("db_absent", ADDR_DEBOUNCE, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
